// File: rtl/arbitro_pkg.sv
// Shared types for the shared-memory arbiter.
// State/owner enums and counter sizing.
package arbitro_pkg;

  localparam int ARB_STATE_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic [ARB_STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Fetch wins if alone, or on a tie when data
  // owned the previous transaction.
  function automatic logic fetch_wins(
    input logic   f_req,
    input logic   d_req,
    input owner_t last
  );
    return f_req & (~d_req | (last == OWN_DATA));
  endfunction

endpackage

// File: rtl/arbitro_memoria_contador_espera.sv
// Read-latency wait counter: clear/enable up-counter.
// Ports: Clock, Reset, clr, en in; hit out at READ_LAT-1.
module contador_espera
  import arbitro_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] HIT_V =
    CNT_W'(READ_LAT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == HIT_V);

endmodule

// File: rtl/arbitro_memoria.sv
// Fetch/data arbiter and sequencer for one shared memory port.
// Ports: f_* fetch req/gnt/done, d_* data req/gnt/done, mem_* memory side.
module arbitro_memoria
  import arbitro_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   f_req,
  input  logic [ADDR_W-1:0]      f_addr,
  output logic                   f_gnt,
  output logic                   f_done,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_W-1:0]      d_addr,
  input  logic [DATA_W-1:0]      d_wdata,
  output logic                   d_gnt,
  output logic                   d_done,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy,
  output logic [ARB_STATE_W-1:0] arb_state
);

  arb_state_t        state;
  owner_t            owner;
  owner_t            last_owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              f_gnt_q;
  logic              d_gnt_q;
  logic              f_done_q;
  logic              d_done_q;
  logic              f_win;
  logic              d_win;
  logic              hit;

  assign f_win = fetch_wins(f_req, d_req, last_owner);
  assign d_win = d_req & ~f_win;

  // Counter is held at zero outside READ, so it
  // starts every read from 0.
  contador_espera #(
    .READ_LAT(READ_LAT)
  ) u_cnt (
    .Clock(Clock),
    .Reset(Reset),
    .clr  (state != ST_READ),
    .en   (state == ST_READ),
    .hit  (hit)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_FETCH;
      last_owner <= OWN_DATA;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      f_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      f_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      f_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (f_win) begin
            owner    <= OWN_FETCH;
            lat_addr <= f_addr;
            f_gnt_q  <= 1'b1;
            state    <= ST_READ;
          end else if (d_win) begin
            owner     <= OWN_DATA;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            d_gnt_q   <= 1'b1;
            state     <= d_we ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (hit) begin
            rdata_q  <= mem_rdata;
            f_done_q <= (owner == OWN_FETCH);
            d_done_q <= (owner == OWN_DATA);
            state    <= ST_RESP;
          end
        end
        ST_WRITE: begin
          f_done_q <= (owner == OWN_FETCH);
          d_done_q <= (owner == OWN_DATA);
          state    <= ST_RESP;
        end
        ST_RESP: begin
          last_owner <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_we    = (state == ST_WRITE);
  assign busy      = (state != ST_IDLE);
  assign arb_state = state;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: transaction-level model
// plus directed literal checks, LAT=2 and LAT=1 builds.
module tb_arbitro_memoria;

  localparam int LAT = 2;

  logic        Clock;
  logic        Reset;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic        f_gnt, f_done, d_gnt, d_done;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;
  logic [1:0]  arb_state;

  logic        u1_f_req, u1_d_req, u1_d_we;
  logic [31:0] u1_f_addr, u1_d_addr, u1_d_wdata;
  logic        u1_f_gnt, u1_f_done, u1_d_gnt, u1_d_done;
  logic [31:0] u1_rdata, u1_mem_addr, u1_mem_wdata;
  logic [31:0] u1_mem_rdata;
  logic        u1_mem_we, u1_busy;
  logic [1:0]  u1_arb_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  arbitro_memoria #(.READ_LAT(LAT)) dut (
    .Clock(Clock), .Reset(Reset),
    .f_req(f_req), .f_addr(f_addr),
    .f_gnt(f_gnt), .f_done(f_done),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done),
    .rdata(rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .arb_state(arb_state)
  );

  arbitro_memoria #(.READ_LAT(1)) dut1 (
    .Clock(Clock), .Reset(Reset),
    .f_req(u1_f_req), .f_addr(u1_f_addr),
    .f_gnt(u1_f_gnt), .f_done(u1_f_done),
    .d_req(u1_d_req), .d_we(u1_d_we),
    .d_addr(u1_d_addr), .d_wdata(u1_d_wdata),
    .d_gnt(u1_d_gnt), .d_done(u1_d_done),
    .rdata(u1_rdata), .mem_addr(u1_mem_addr),
    .mem_we(u1_mem_we), .mem_wdata(u1_mem_wdata),
    .mem_rdata(u1_mem_rdata), .busy(u1_busy),
    .arb_state(u1_arb_state)
  );

  assign u1_mem_rdata = u1_mem_addr ^ 32'hCAFE0000;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hsh(
    input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Environment memory seen by the DUT.
  logic [31:0] env_mem [logic [31:0]];
  // Model's own view of memory contents.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] env_rd(
    input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return hsh(a);
  endfunction

  function automatic logic [31:0] ref_rd(
    input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return hsh(a);
  endfunction

  always @(negedge Clock)
    if (mem_we === 1'b1) env_mem[mem_addr] = mem_wdata;

  // Transaction model: m_t counts cycles since the
  // accepting edge (1 = grant cycle); m_len busy
  // cycles precede the done cycle.
  logic        m_busy = 1'b0;
  logic        m_own = 1'b0;
  logic        m_we = 1'b0;
  logic        m_last = 1'b1;
  int          m_t = 0;
  int          m_len = 0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic [31:0] e_rdata = '0;

  always @(posedge Clock) begin
    cyc++;
    // memory commits a write on the edge ending it
    if (m_busy && m_we && m_t == 1)
      ref_mem[e_addr] = e_wdata;
    if (Reset) begin
      m_busy = 0; m_t = 0; m_last = 1;
      e_addr = 0; e_wdata = 0; e_rdata = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == m_len + 1 && !m_we)
        e_rdata = ref_rd(e_addr);
      else if (m_t == m_len + 2) begin
        m_busy = 0;
        m_last = m_own;
      end
    end else if (f_req || d_req) begin
      m_own = (f_req && d_req) ? !m_last : d_req;
      m_busy = 1;
      m_t = 1;
      if (m_own) begin
        e_addr = d_addr;
        e_wdata = d_wdata;
        m_we = d_we;
      end else begin
        e_addr = f_addr;
        m_we = 0;
      end
      m_len = m_we ? 1 : LAT;
    end
    #1;
    chk("f_gnt", 32'(f_gnt),
        32'(m_busy && m_t == 1 && !m_own));
    chk("d_gnt", 32'(d_gnt),
        32'(m_busy && m_t == 1 && m_own));
    chk("f_done", 32'(f_done),
        32'(m_busy && m_t == m_len + 1 && !m_own));
    chk("d_done", 32'(d_done),
        32'(m_busy && m_t == m_len + 1 && m_own));
    chk("mem_we", 32'(mem_we),
        32'(m_busy && m_we && m_t == 1));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("arb_state", 32'(arb_state),
        !m_busy ? 0 :
        (m_t <= m_len) ? (m_we ? 2 : 1) : 3);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("rdata", rdata, e_rdata);
    mem_rdata = env_rd(mem_addr);
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return f_gnt;
      1: return f_done;
      2: return d_gnt;
      3: return d_done;
      4: return u1_d_gnt;
      5: return u1_d_done;
      default: return f_gnt | d_gnt;
    endcase
  endfunction

  task automatic wait_hi(input int sel,
                         input string nm,
                         output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (sig(sel) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL %s got=none exp=pulse", nm);
    end
  endtask

  int       c0, g, d, fg_cnt;
  logic [3:0] seq;

  initial begin
    Reset = 1; mem_rdata = 0;
    f_req = 0; d_req = 0; d_we = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0;
    u1_f_req = 0; u1_d_req = 0; u1_d_we = 0;
    u1_f_addr = 0; u1_d_addr = 0; u1_d_wdata = 0;
    env_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;
    repeat (3) @(negedge Clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(arb_state), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", 32'(mem_we), 0);
    Reset = 0;

    // READ_LAT=1: load then store back-to-back
    u1_d_req = 1; u1_d_we = 0; u1_d_addr = 32'h80;
    c0 = cyc;
    wait_hi(4, "u1_ld_gnt", g);
    chk("u1_ld_gnt_lat", g, c0 + 1);
    u1_d_we = 1; u1_d_addr = 32'h84;
    u1_d_wdata = 32'h55;
    wait_hi(5, "u1_ld_done", d);
    chk("u1_ld_done_lat", d, c0 + 2);
    chk("u1_rdata", u1_rdata, 32'hCAFE0080);
    wait_hi(4, "u1_st_gnt", g);
    chk("u1_st_gnt_lat", g, d + 2);
    chk("u1_st_we", 32'(u1_mem_we), 1);
    chk("u1_st_addr", u1_mem_addr, 32'h84);
    u1_d_req = 0; u1_d_we = 0;
    wait_hi(5, "u1_st_done", d);
    chk("u1_st_done_lat", d, g + 1);

    // single fetch
    @(negedge Clock);
    f_req = 1; f_addr = 32'h10; c0 = cyc;
    wait_hi(0, "fetch_gnt", g);
    f_req = 0;
    chk("fetch_gnt_lat", g, c0 + 1);
    chk("fetch_addr", mem_addr, 32'h10);
    wait_hi(1, "fetch_done", d);
    chk("fetch_done_lat", d - g, 2);
    chk("fetch_rdata", rdata, 32'hDEADBEEF);

    // single store
    d_req = 1; d_we = 1;
    d_addr = 32'h40; d_wdata = 32'h1234;
    wait_hi(2, "store_gnt", g);
    chk("store_we", 32'(mem_we), 1);
    chk("store_wdata", mem_wdata, 32'h1234);
    d_req = 0; d_we = 0;
    @(negedge Clock);
    chk("store_done", 32'(d_done), 1);
    chk("store_we_off", 32'(mem_we), 0);
    repeat (3) @(negedge Clock);

    // both loads held: round-robin F,D,F,D
    f_req = 1; d_req = 1; d_we = 0;
    f_addr = 32'h100; d_addr = 32'h40;
    seq = 0;
    for (int i = 0; i < 4; i++) begin
      wait_hi(6, "rr_gnt", g);
      seq = {seq[2:0], d_gnt};
    end
    chk("rr_order", 32'(seq), 32'b0101);
    f_req = 0; d_req = 0;
    repeat (6) @(negedge Clock);
    chk("rr_rdata", rdata, 32'h1234);

    // reset during READ cycle 1
    f_req = 1; f_addr = 32'h20;
    wait_hi(0, "rst_gnt", g);
    Reset = 1; f_req = 0;
    @(negedge Clock);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_state", 32'(arb_state), 0);
    chk("mid_rdata", rdata, 0);
    Reset = 0;
    fg_cnt = 0;
    repeat (4) begin
      @(negedge Clock);
      fg_cnt += 32'(f_done);
    end
    chk("mid_no_done", fg_cnt, 0);
    f_req = 1; f_addr = 32'h24;
    wait_hi(0, "fresh_gnt", g);
    f_req = 0;
    wait_hi(1, "fresh_done", d);
    chk("fresh_rdata", rdata, hsh(32'h24));

    // fetch pulsed only while busy: never granted
    d_req = 1; d_we = 0; d_addr = 32'h30;
    wait_hi(2, "pulse_dgnt", g);
    d_req = 0; f_req = 1; f_addr = 32'h50;
    fg_cnt = 0;
    @(negedge Clock);
    fg_cnt += 32'(f_gnt);
    @(negedge Clock);
    f_req = 0;
    repeat (8) begin
      @(negedge Clock);
      fg_cnt += 32'(f_gnt);
    end
    chk("pulse_no_fgnt", fg_cnt, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge Clock);
      Reset = ($urandom_range(99) == 0);
      f_req = ($urandom_range(2) != 0);
      d_req = ($urandom_range(2) != 0);
      d_we = $urandom_range(1);
      f_addr = 32'($urandom_range(15)) << 2;
      d_addr = 32'($urandom_range(15)) << 2;
      d_wdata = $urandom;
    end
    @(negedge Clock);
    Reset = 0; f_req = 0; d_req = 0;
    repeat (8) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
